cpu_boot_sequencer: RTL and testbench
=====================================

Name: cpu_boot_sequencer

Overview:
Synthesizable program loader and run controller for the cpu core. On start, it copies PROG_LEN instruction words from a synchronous program ROM into the CPU instruction memory and holds the CPU in reset for RESET_CYCLES. It then releases the CPU and runs it until the CPU signals halt or a cycle budget expires, and reports done/timeout/cycle count. This replaces hand-poked imem initialisation and fixed-delay runs with a reusable, parametrised sequence usable in simulation and on FPGA.

Parameters:
INSTR_WIDTH, 16, width of one instruction word
ADDR_WIDTH, 8, instruction memory address width; PROG_LEN <= 2**ADDR_WIDTH
PROG_LEN, 16, number of words copied per load (>= 1)
RESET_CYCLES, 2, cycles cpu_reset stays high after load completes (>= 1)
RUN_CYCLES, 100, maximum CPU run cycles before timeout (>= 1)
CNT_WIDTH, $clog2(RUN_CYCLES+1), width of cycle_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin load+run; ignored unless IDLE or DONE
src_addr  output  ADDR_WIDTH  program ROM read address
src_data  input  INSTR_WIDTH  program ROM data, valid one cycle after src_addr
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_WIDTH  instruction memory write address
imem_wdata  output  INSTR_WIDTH  instruction memory write data (= src_data)
cpu_reset  output  1  reset to cpu core, active-high
cpu_halt  input  1  cpu reports halt (level, sampled in RUN only)
busy  output  1  high in LOAD, HOLD, RUN
done  output  1  high in DONE
timeout  output  1  valid while done; 1 = budget expired without halt
cycle_count  output  CNT_WIDTH  CPU run cycles of current/last run

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, src_addr=0, imem_we=0, imem_addr=0, cpu_reset=1, busy=0, done=0, timeout=0, cycle_count=0. Reset mid-operation aborts immediately, with no further imem writes.
- States: IDLE, LOAD, HOLD, RUN, DONE.
- IDLE: cpu_reset=1. start -> LOAD next cycle; rd_ptr=0; cycle_count, timeout cleared.
- LOAD: src_addr=rd_ptr; rd_ptr increments each cycle up to PROG_LEN-1, then stops issuing. Write stage is registered: imem_we/imem_addr are the previous cycle's issue-valid/src_addr, and imem_wdata=src_data. Exactly PROG_LEN writes to addresses 0..PROG_LEN-1, in order, with no gaps. LOAD lasts PROG_LEN+1 cycles; the cycle after the last write, state=HOLD.
- HOLD: imem_we=0, cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: cpu_reset=0. cycle_count increments by 1 every RUN cycle, starting from 1 on the first RUN cycle. Exits on the first of:
  - cpu_halt=1 -> DONE with timeout=0.
  - cycle_count==RUN_CYCLES at end of cycle -> DONE with timeout=1.
  - If both occur in the same cycle, halt wins (timeout=0).
- DONE: done=1, cpu_reset=1 (CPU frozen), cycle_count held. start -> LOAD with done, timeout and cycle_count cleared.
- start while busy: ignored, with no effect on state or counters.
- cycle_count saturates at RUN_CYCLES and never wraps.
- cpu_halt is ignored outside RUN.
- All outputs are registered except imem_wdata.

Test Plan:
- Load: PROG_LEN=4, ROM={0x1111,0x2222,0x3333,0x4444}, pulse start -> imem_we high for exactly 4 consecutive cycles with addr 0,1,2,3 and data as listed; cpu_reset stays 1 through load and for 2 HOLD cycles.
- Halt: RUN_CYCLES=100, cpu_halt asserted on 7th RUN cycle -> done=1, timeout=0, cycle_count=7, cpu_reset back to 1 the next cycle.
- Timeout: cpu_halt held 0, RUN_CYCLES=10 -> done after 10 RUN cycles, timeout=1, cycle_count=10, with no wrap over the next 20 cycles.
- Tie: cpu_halt first asserted on RUN cycle 10 with RUN_CYCLES=10 -> timeout=0, cycle_count=10.
- Busy/restart: start pulsed during LOAD and RUN -> ignored, write sequence unchanged. start in DONE -> done/timeout/count cleared and a new 4-word load occurs.
- Reset mid-run: reset asserted in LOAD after 2 writes -> next cycle IDLE, imem_we=0, cpu_reset=1, all status zero. A later start loads a full 4 words from address 0.

Source files
------------

// File: rtl/cpu_boot_sequencer_if.sv
// Bus bundle between the boot sequencer, the program ROM, the CPU
// instruction memory and the CPU core control/status lines.
interface cpu_boot_sequencer_if #(
   parameter int unsigned INSTR_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH   = 7
);
   logic                   start;
   logic [ADDR_WIDTH-1:0]  src_addr;
   logic [INSTR_WIDTH-1:0] src_data;
   logic                   imem_we;
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic [INSTR_WIDTH-1:0] imem_wdata;
   logic                   cpu_reset;
   logic                   cpu_halt;
   logic                   busy;
   logic                   done;
   logic                   timeout;
   logic [CNT_WIDTH-1:0]   cycle_count;

   // Sequencer side
   modport master (
      input  start, src_data, cpu_halt,
      output src_addr, imem_we, imem_addr, imem_wdata,
             cpu_reset, busy, done, timeout, cycle_count
   );

   // Environment side (ROM, imem, CPU, controller)
   modport slave (
      output start, src_data, cpu_halt,
      input  src_addr, imem_we, imem_addr, imem_wdata,
             cpu_reset, busy, done, timeout, cycle_count
   );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// Program loader and run controller: copies PROG_LEN words from a synchronous
// ROM into CPU instruction memory, holds the CPU in reset, then runs it until
// halt or until the cycle budget is exhausted.
module cpu_boot_sequencer #(
   parameter int unsigned INSTR_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned PROG_LEN     = 16,
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned RUN_CYCLES   = 100,
   parameter int unsigned CNT_WIDTH    = $clog2(RUN_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                reset,
   cpu_boot_sequencer_if.master bus
);

   localparam int unsigned HOLD_WIDTH = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(RUN_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   state_t                  state;
   logic                    issue;
   logic [HOLD_WIDTH-1:0]   hold_cnt;
   logic [INSTR_WIDTH-1:0]  wdata_c;

   // Write data passes straight through: the ROM output lines up with the
   // registered write address/enable one cycle after the read was issued.
   assign wdata_c        = bus.src_data;
   assign bus.imem_wdata = wdata_c;

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         issue           <= 1'b0;
         hold_cnt        <= '0;
         bus.src_addr    <= '0;
         bus.imem_we     <= 1'b0;
         bus.imem_addr   <= '0;
         bus.cpu_reset   <= 1'b1;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.timeout     <= 1'b0;
         bus.cycle_count <= '0;
      end else begin
         bus.imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state           <= S_LOAD;
                  issue           <= 1'b1;
                  bus.src_addr    <= '0;
                  bus.busy        <= 1'b1;
                  bus.done        <= 1'b0;
                  bus.timeout     <= 1'b0;
                  bus.cycle_count <= '0;
               end
            end

            S_LOAD: begin
               // Write stage trails the read stage by one cycle
               bus.imem_we   <= issue;
               bus.imem_addr <= bus.src_addr;
               if (issue) begin
                  if (bus.src_addr == LAST_ADDR) begin
                     issue <= 1'b0;
                  end else begin
                     bus.src_addr <= bus.src_addr + ADDR_WIDTH'(1);
                  end
               end
               // Last word is being written this cycle
               if (bus.imem_we && (bus.imem_addr == LAST_ADDR)) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
               end
            end

            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state           <= S_RUN;
                  bus.cpu_reset   <= 1'b0;
                  bus.cycle_count <= CNT_WIDTH'(1);
               end else begin
                  hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
               end
            end

            S_RUN: begin
               // Halt takes priority over budget expiry in the same cycle
               if (bus.cpu_halt) begin
                  state         <= S_DONE;
                  bus.cpu_reset <= 1'b1;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
                  bus.timeout   <= 1'b0;
               end else if (bus.cycle_count == CNT_MAX) begin
                  state         <= S_DONE;
                  bus.cpu_reset <= 1'b1;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
                  bus.timeout   <= 1'b1;
               end else begin
                  bus.cycle_count <= bus.cycle_count + CNT_WIDTH'(1);
               end
            end

            default: begin
               state         <= S_IDLE;
               issue         <= 1'b0;
               bus.cpu_reset <= 1'b1;
               bus.busy      <= 1'b0;
               bus.done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench for cpu_boot_sequencer: two instances, one with a long run
// budget (load / halt / restart / reset scenarios) and one with a short
// budget (timeout and halt-vs-timeout tie).
module tb_cpu_boot_sequencer;

   logic clk;
   logic reset;

   int checks;
   int fails;

   logic [15:0] rom [4];

   cpu_boot_sequencer_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .CNT_WIDTH(7)) bus_a ();
   cpu_boot_sequencer_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .CNT_WIDTH(4)) bus_b ();

   cpu_boot_sequencer #(
      .INSTR_WIDTH(16), .ADDR_WIDTH(8), .PROG_LEN(4),
      .RESET_CYCLES(2), .RUN_CYCLES(100), .CNT_WIDTH(7)
   ) dut_a (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_a)
   );

   cpu_boot_sequencer #(
      .INSTR_WIDTH(16), .ADDR_WIDTH(8), .PROG_LEN(4),
      .RESET_CYCLES(2), .RUN_CYCLES(10), .CNT_WIDTH(4)
   ) dut_b (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_b)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program ROMs
   always @(posedge clk) begin
      bus_a.src_data <= rom[bus_a.src_addr[1:0]];
      bus_b.src_data <= rom[bus_b.src_addr[1:0]];
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", bus_a.busy); end
      checks++; if (bus_a.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", bus_a.done); end
      checks++; if (bus_a.timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %0b expected 0", bus_a.timeout); end
      checks++; if (bus_a.cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %0b expected 1", bus_a.cpu_reset); end
      checks++; if (bus_a.imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %0b expected 0", bus_a.imem_we); end
      checks++; if (bus_a.imem_addr !== 8'h00) begin fails++; $display("FAIL reset_imem_addr: got %0h expected 0", bus_a.imem_addr); end
      checks++; if (bus_a.src_addr !== 8'h00) begin fails++; $display("FAIL reset_src_addr: got %0h expected 0", bus_a.src_addr); end
      checks++; if (bus_a.cycle_count !== 7'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus_a.cycle_count); end
      checks++; if (bus_b.cpu_reset !== 1'b1 || bus_b.busy !== 1'b0) begin fails++; $display("FAIL reset_b: got cpu_reset=%0b busy=%0b expected 1/0", bus_b.cpu_reset, bus_b.busy); end
      reset = 1'b0;
      // Halt while idle must be ignored
      bus_a.cpu_halt = 1'b1;
      repeat (2) @(negedge clk);
      bus_a.cpu_halt = 1'b0;
      checks++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin fails++; $display("FAIL idle_halt: got busy=%0b done=%0b expected 0/0", bus_a.busy, bus_a.done); end
   endtask

   task automatic test_load();
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++; if (bus_a.busy !== 1'b1 || bus_a.imem_we !== 1'b0) begin fails++; $display("FAIL load_first: got busy=%0b we=%0b expected 1/0", bus_a.busy, bus_a.imem_we); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus_a.imem_we !== 1'b1) begin fails++; $display("FAIL load_we%0d: got %0b expected 1", i, bus_a.imem_we); end
         checks++; if (bus_a.imem_addr !== 8'(i)) begin fails++; $display("FAIL load_addr%0d: got %0h expected %0h", i, bus_a.imem_addr, i); end
         checks++; if (bus_a.imem_wdata !== rom[i]) begin fails++; $display("FAIL load_data%0d: got %0h expected %0h", i, bus_a.imem_wdata, rom[i]); end
         checks++; if (bus_a.cpu_reset !== 1'b1) begin fails++; $display("FAIL load_cpu_reset%0d: got %0b expected 1", i, bus_a.cpu_reset); end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (bus_a.imem_we !== 1'b0 || bus_a.cpu_reset !== 1'b1 || bus_a.busy !== 1'b1) begin fails++; $display("FAIL hold%0d: got we=%0b cpu_reset=%0b busy=%0b expected 0/1/1", i, bus_a.imem_we, bus_a.cpu_reset, bus_a.busy); end
      end
      @(negedge clk);
      checks++; if (bus_a.cpu_reset !== 1'b0) begin fails++; $display("FAIL run_cpu_reset: got %0b expected 0", bus_a.cpu_reset); end
      checks++; if (bus_a.cycle_count !== 7'd1) begin fails++; $display("FAIL run_first_count: got %0d expected 1", bus_a.cycle_count); end
   endtask

   task automatic test_halt();
      repeat (6) @(negedge clk);
      checks++; if (bus_a.cycle_count !== 7'd7 || bus_a.done !== 1'b0) begin fails++; $display("FAIL halt_pre: got count=%0d done=%0b expected 7/0", bus_a.cycle_count, bus_a.done); end
      bus_a.cpu_halt = 1'b1;
      @(negedge clk);
      bus_a.cpu_halt = 1'b0;
      checks++; if (bus_a.done !== 1'b1) begin fails++; $display("FAIL halt_done: got %0b expected 1", bus_a.done); end
      checks++; if (bus_a.timeout !== 1'b0) begin fails++; $display("FAIL halt_timeout: got %0b expected 0", bus_a.timeout); end
      checks++; if (bus_a.cycle_count !== 7'd7) begin fails++; $display("FAIL halt_count: got %0d expected 7", bus_a.cycle_count); end
      checks++; if (bus_a.cpu_reset !== 1'b1 || bus_a.busy !== 1'b0) begin fails++; $display("FAIL halt_cpu_reset: got cpu_reset=%0b busy=%0b expected 1/0", bus_a.cpu_reset, bus_a.busy); end
      bus_a.cpu_halt = 1'b1;
      repeat (3) @(negedge clk);
      bus_a.cpu_halt = 1'b0;
      checks++; if (bus_a.done !== 1'b1 || bus_a.cycle_count !== 7'd7) begin fails++; $display("FAIL done_hold: got done=%0b count=%0d expected 1/7", bus_a.done, bus_a.cycle_count); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      repeat (7) @(negedge clk);
      checks++; if (bus_b.cycle_count !== 4'd1 || bus_b.cpu_reset !== 1'b0) begin fails++; $display("FAIL to_first: got count=%0d cpu_reset=%0b expected 1/0", bus_b.cycle_count, bus_b.cpu_reset); end
      repeat (9) @(negedge clk);
      checks++; if (bus_b.cycle_count !== 4'd10 || bus_b.done !== 1'b0) begin fails++; $display("FAIL to_last: got count=%0d done=%0b expected 10/0", bus_b.cycle_count, bus_b.done); end
      @(negedge clk);
      checks++; if (bus_b.done !== 1'b1) begin fails++; $display("FAIL to_done: got %0b expected 1", bus_b.done); end
      checks++; if (bus_b.timeout !== 1'b1) begin fails++; $display("FAIL to_timeout: got %0b expected 1", bus_b.timeout); end
      checks++; if (bus_b.cycle_count !== 4'd10) begin fails++; $display("FAIL to_count: got %0d expected 10", bus_b.cycle_count); end
      checks++; if (bus_b.cpu_reset !== 1'b1) begin fails++; $display("FAIL to_cpu_reset: got %0b expected 1", bus_b.cpu_reset); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (bus_b.cycle_count !== 4'd10 || bus_b.done !== 1'b1) begin fails++; $display("FAIL to_nowrap%0d: got count=%0d done=%0b expected 10/1", i, bus_b.cycle_count, bus_b.done); end
      end
   endtask

   task automatic test_tie();
      @(negedge clk);
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      checks++; if (bus_b.done !== 1'b0 || bus_b.timeout !== 1'b0 || bus_b.cycle_count !== 4'd0 || bus_b.busy !== 1'b1) begin fails++; $display("FAIL tie_clear: got done=%0b timeout=%0b count=%0d busy=%0b expected 0/0/0/1", bus_b.done, bus_b.timeout, bus_b.cycle_count, bus_b.busy); end
      repeat (16) @(negedge clk);
      checks++; if (bus_b.cycle_count !== 4'd10 || bus_b.done !== 1'b0) begin fails++; $display("FAIL tie_pre: got count=%0d done=%0b expected 10/0", bus_b.cycle_count, bus_b.done); end
      bus_b.cpu_halt = 1'b1;
      @(negedge clk);
      bus_b.cpu_halt = 1'b0;
      checks++; if (bus_b.done !== 1'b1 || bus_b.timeout !== 1'b0 || bus_b.cycle_count !== 4'd10) begin fails++; $display("FAIL tie_result: got done=%0b timeout=%0b count=%0d expected 1/0/10", bus_b.done, bus_b.timeout, bus_b.cycle_count); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++; if (bus_a.done !== 1'b0 || bus_a.timeout !== 1'b0 || bus_a.cycle_count !== 7'd0 || bus_a.busy !== 1'b1) begin fails++; $display("FAIL b2b_clear: got done=%0b timeout=%0b count=%0d busy=%0b expected 0/0/0/1", bus_a.done, bus_a.timeout, bus_a.cycle_count, bus_a.busy); end
      bus_a.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_a.start = 1'b0;
         checks++; if (bus_a.imem_we !== 1'b1 || bus_a.imem_addr !== 8'(i) || bus_a.imem_wdata !== rom[i]) begin fails++; $display("FAIL b2b_write%0d: got we=%0b addr=%0h data=%0h expected 1/%0h/%0h", i, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, i, rom[i]); end
      end
      repeat (2) @(negedge clk);
      checks++; if (bus_a.imem_we !== 1'b0 || bus_a.cpu_reset !== 1'b1) begin fails++; $display("FAIL b2b_hold: got we=%0b cpu_reset=%0b expected 0/1", bus_a.imem_we, bus_a.cpu_reset); end
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++; if (bus_a.cycle_count !== 7'd2 || bus_a.busy !== 1'b1 || bus_a.cpu_reset !== 1'b0) begin fails++; $display("FAIL b2b_run_start: got count=%0d busy=%0b cpu_reset=%0b expected 2/1/0", bus_a.cycle_count, bus_a.busy, bus_a.cpu_reset); end
      bus_a.cpu_halt = 1'b1;
      @(negedge clk);
      bus_a.cpu_halt = 1'b0;
      checks++; if (bus_a.done !== 1'b1 || bus_a.cycle_count !== 7'd2 || bus_a.timeout !== 1'b0) begin fails++; $display("FAIL b2b_done: got done=%0b count=%0d timeout=%0b expected 1/2/0", bus_a.done, bus_a.cycle_count, bus_a.timeout); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      @(negedge clk);
      checks++; if (bus_a.imem_we !== 1'b1 || bus_a.imem_addr !== 8'h00) begin fails++; $display("FAIL mid_w0: got we=%0b addr=%0h expected 1/0", bus_a.imem_we, bus_a.imem_addr); end
      @(negedge clk);
      checks++; if (bus_a.imem_we !== 1'b1 || bus_a.imem_addr !== 8'h01) begin fails++; $display("FAIL mid_w1: got we=%0b addr=%0h expected 1/1", bus_a.imem_we, bus_a.imem_addr); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus_a.imem_we !== 1'b0 || bus_a.cpu_reset !== 1'b1) begin fails++; $display("FAIL mid_abort: got we=%0b cpu_reset=%0b expected 0/1", bus_a.imem_we, bus_a.cpu_reset); end
      checks++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.timeout !== 1'b0 || bus_a.cycle_count !== 7'd0) begin fails++; $display("FAIL mid_status: got busy=%0b done=%0b timeout=%0b count=%0d expected 0/0/0/0", bus_a.busy, bus_a.done, bus_a.timeout, bus_a.cycle_count); end
      checks++; if (bus_a.src_addr !== 8'h00 || bus_a.imem_addr !== 8'h00) begin fails++; $display("FAIL mid_addr: got src=%0h imem=%0h expected 0/0", bus_a.src_addr, bus_a.imem_addr); end
      @(negedge clk);
      checks++; if (bus_a.imem_we !== 1'b0 || bus_a.busy !== 1'b0) begin fails++; $display("FAIL mid_idle: got we=%0b busy=%0b expected 0/0", bus_a.imem_we, bus_a.busy); end
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      checks++; if (bus_a.imem_we !== 1'b0 || bus_a.busy !== 1'b1) begin fails++; $display("FAIL reload_first: got we=%0b busy=%0b expected 0/1", bus_a.imem_we, bus_a.busy); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus_a.imem_we !== 1'b1 || bus_a.imem_addr !== 8'(i) || bus_a.imem_wdata !== rom[i]) begin fails++; $display("FAIL reload_write%0d: got we=%0b addr=%0h data=%0h expected 1/%0h/%0h", i, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, i, rom[i]); end
      end
      @(negedge clk);
      checks++; if (bus_a.imem_we !== 1'b0) begin fails++; $display("FAIL reload_end: got we=%0b expected 0", bus_a.imem_we); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rom[0] = 16'h1111;
      rom[1] = 16'h2222;
      rom[2] = 16'h3333;
      rom[3] = 16'h4444;
      reset          = 1'b1;
      bus_a.start    = 1'b0;
      bus_a.cpu_halt = 1'b0;
      bus_b.start    = 1'b0;
      bus_b.cpu_halt = 1'b0;

      test_reset();
      test_load();
      test_halt();
      test_timeout();
      test_tie();
      test_back_to_back();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
